// File: rtl/ram_data_disp.sv
// RAM data display back-end: 8-bit word -> 3 BCD digits (sequential double-dabble) -> 6-digit
// multiplexed common-anode 7-seg scan. Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros.
module ram_data_disp #(
    parameter logic [15:0] CNT_SCAN = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        data_en,
    input  logic [7:0]  data_in,
    output logic [11:0] bcd_out,
    output logic        conv_done,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  last_q, last_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [9:0]  bcd_w_q, bcd_w_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [11:0] bcd_out_q, bcd_out_d;
    logic        conv_done_q, conv_done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;

    logic [3:0]  ones_adj, tens_adj;
    logic [17:0] sh_all;
    logic [3:0]  nib;
    logic        blank_h, blank_t;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Conversion FSM: one add-3/shift step per SHIFT cycle, eight steps per word.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        shreg_d     = shreg_q;
        bcd_w_d     = bcd_w_q;
        bit_cnt_d   = bit_cnt_q;
        bcd_out_d   = bcd_out_q;
        conv_done_d = 1'b0;
        ones_adj    = (bcd_w_q[3:0] >= 4'd5) ? bcd_w_q[3:0] + 4'd3 : bcd_w_q[3:0];
        tens_adj    = (bcd_w_q[7:4] >= 4'd5) ? bcd_w_q[7:4] + 4'd3 : bcd_w_q[7:4];
        sh_all      = {bcd_w_q[9:8], tens_adj, ones_adj, shreg_q} << 1;
        case (state_q)
            IDLE: begin
                if (data_in != last_q) begin
                    shreg_d   = data_in;
                    bcd_w_d   = 10'd0;
                    last_d    = data_in;
                    bit_cnt_d = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                bcd_w_d   = sh_all[17:8];
                shreg_d   = sh_all[7:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_out_d   = {2'b00, bcd_w_q};
                conv_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
        blank_h = (bcd_out_q[11:8] == 4'd0);
        blank_t = (bcd_out_q[11:8] == 4'd0) && (bcd_out_q[7:4] == 4'd0);
`else
        blank_h = 1'b0;
        blank_t = 1'b0;
`endif
    end

    // Scanner: index advances once per dwell period; outputs lag index and bcd_out by one cycle.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        sel_d = 6'h3F;
        seg_d = 8'hFF;
        nib   = 4'd0;
        if (data_en) begin
            if (cnt_q == CNT_SCAN) begin
                cnt_d = 16'd0;
                idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            sel_d = ~(6'b00_0001 << idx_q);
            case (idx_q)
                3'd0: begin
                    nib   = bcd_out_q[3:0];
                    seg_d = seg_code(nib);
                end
                3'd1: begin
                    nib   = bcd_out_q[7:4];
                    seg_d = blank_t ? 8'hFF : seg_code(nib);
                end
                3'd2: begin
                    nib   = bcd_out_q[11:8];
                    seg_d = blank_h ? 8'hFF : seg_code(nib);
                end
                default: seg_d = 8'hFF;
            endcase
        end else begin
            cnt_d = 16'd0;
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            last_q      <= 8'd0;
            shreg_q     <= 8'd0;
            bcd_w_q     <= 10'd0;
            bit_cnt_q   <= 3'd0;
            bcd_out_q   <= 12'h000;
            conv_done_q <= 1'b0;
            cnt_q       <= 16'd0;
            idx_q       <= 3'd0;
            sel_q       <= 6'h3F;
            seg_q       <= 8'hFF;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            shreg_q     <= shreg_d;
            bcd_w_q     <= bcd_w_d;
            bit_cnt_q   <= bit_cnt_d;
            bcd_out_q   <= bcd_out_d;
            conv_done_q <= conv_done_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign bcd_out   = bcd_out_q;
    assign conv_done = conv_done_q;
    assign sel       = sel_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_ram_data_disp.sv
// Randomized + directed bench for ram_data_disp against a cycle-level arithmetic reference model.
module tb_ram_data_disp;

    localparam logic [15:0] CNT_SCAN = 16'd3;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  din;
    logic [11:0] bcd_out;
    logic        conv_done;
    logic [5:0]  sel;
    logic [7:0]  seg;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: busy counts down the 9 edges after a conversion starts.
    int   m_last, m_busy, m_pend, m_disp, m_k;
    logic m_done;
    logic [5:0] m_sel;
    logic [7:0] m_seg;

    ram_data_disp #(.CNT_SCAN(CNT_SCAN)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .data_en  (en),
        .data_in  (din),
        .bcd_out  (bcd_out),
        .conv_done(conv_done),
        .sel      (sel),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [7:0] digit_code(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (idx)
            0: return digit_code(o);
`ifdef LEAD_ZERO_BLANK_EN
            1: return (h == 0 && t == 0) ? 8'hFF : digit_code(t);
            2: return (h == 0) ? 8'hFF : digit_code(h);
`else
            1: return digit_code(t);
            2: return digit_code(h);
`endif
            default: return 8'hFF;
        endcase
    endfunction

    task automatic step();
        int idx;
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_last = 0; m_busy = 0; m_pend = 0; m_disp = 0; m_k = 0;
            m_sel = 6'h3F; m_seg = 8'hFF;
        end else begin
            if (en) begin
                idx   = (m_k / DWELL) % 6;
                m_sel = ~(6'(1) << idx);
                m_seg = exp_seg(idx, m_disp);
                m_k++;
            end else begin
                m_k   = 0;
                m_sel = 6'h3F;
                m_seg = 8'hFF;
            end
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_disp = m_pend;
                    m_done = 1'b1;
                end
            end else if (int'(din) != m_last) begin
                m_last = int'(din);
                m_pend = int'(din);
                m_busy = 9;
            end
        end
        #1;
        check_val("bcd_out", 32'(bcd_out), 32'(to_bcd(m_disp)));
        check_val("conv_done", 32'(conv_done), 32'(m_done));
        check_val("sel", 32'(sel), 32'(m_sel));
        check_val("seg", 32'(seg), 32'(m_seg));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din = 8'd0;
        m_last = 0; m_busy = 0; m_pend = 0; m_disp = 0; m_k = 0;
        m_done = 1'b0; m_sel = 6'h3F; m_seg = 8'hFF;
        run(2);
        check_val("rst_sel", 32'(sel), 32'h3F);
        check_val("rst_seg", 32'(seg), 32'hFF);

        rst = 1'b0;
        run(30);

        din = 8'd255;
        run(10);
        check_val("full_done", 32'(conv_done), 32'h1);
        check_val("full_bcd", 32'(bcd_out), 32'h255);
        run(30);

        din = 8'd7;
        run(40);

        din = 8'd100;
        run(3);
        din = 8'd200;
        run(30);
        check_val("chg_bcd", 32'(bcd_out), 32'h200);

        run(5);
        en = 1'b0;
        run(1);
        check_val("dis_sel", 32'(sel), 32'h3F);
        check_val("dis_seg", 32'(seg), 32'hFF);
        run(3);
        en = 1'b1;
        run(1);
        check_val("reen_sel", 32'(sel), 32'h3E);
        run(10);

        din = 8'd55;
        run(4);
        rst = 1'b1;
        run(1);
        check_val("midrst_bcd", 32'(bcd_out), 32'h000);
        check_val("midrst_done", 32'(conv_done), 32'h0);
        rst = 1'b0;
        run(15);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) din = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 30) == 0) en = ~en;
            rst = ($urandom_range(0, 80) == 0);
            step();
        end
        rst = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
